array_wr_ctrl: RTL and testbench

ARRAY_WR_CTRL -- requirements
Module: array_wr_ctrl

---
 rtl/array_ctrl_pkg.sv | 13 +
 rtl/rr_arb2.sv | 25 ++
 rtl/array_wr_ctrl.sv | 114 +++++++++++
 tb/tb_array_wr_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_ctrl_pkg.sv
// Shared defaults and state encoding for the array write controller.
package array_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 4096;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant plus the pointer to use next cycle.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);

  always_comb begin
    grant    = 2'b00;
    ptr_next = ptr;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
    // Pointer moves to the requester that was not served; idle cycles keep it.
    if (grant[0]) begin
      ptr_next = 1'b1;
    end else if (grant[1]) begin
      ptr_next = 1'b0;
    end
  end

endmodule

// File: rtl/array_wr_ctrl.sv
// Array write-port controller: zero-fill sweep after reset/clear, then
// round-robin arbitrated writes from two requesters with registered outputs.
module array_wr_ctrl
  import array_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              clr_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              init_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              ptr_q, ptr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        arb_grant;
  logic              arb_ptr_next;

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .ptr      (ptr_q),
    .grant    (arb_grant),
    .ptr_next (arb_ptr_next)
  );

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    unique case (state_q)
      INIT: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = sweep_q;
        mem_wdata_d = '0;
        sweep_d     = sweep_q + AddrOne;
        if (sweep_q == LastAddr) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // A clear wins over any pending request; nobody is handshaken that cycle.
        if (clr_req) begin
          state_d = INIT;
          sweep_d = '0;
        end else begin
          req0_ready = arb_grant[0];
          req1_ready = arb_grant[1];
          ptr_d      = arb_ptr_next;
          if (|arb_grant) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = arb_grant[1] ? req1_addr : req0_addr;
            mem_wdata_d = arb_grant[1] ? req1_data : req0_data;
          end
        end
      end
      default: state_d = INIT;
    endcase
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      sweep_q     <= '0;
      ptr_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      ptr_q       <= ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign init_done = (state_q == RUN);
  assign busy      = (state_q == INIT);

endmodule

// File: tb/tb_array_wr_ctrl.sv
// Directed self-checking bench for array_wr_ctrl: sweep, arbitration, clear and reset.
module tb_array_wr_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              clr_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              init_done, busy;

  int checks   = 0;
  int failures = 0;

  array_wr_ctrl #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .clr_req    (clr_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .init_done  (init_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects the next edge to present sweep address 0; ends in the first RUN cycle.
  task automatic run_sweep(input string name, input int clr_at);
    int bad_i = -1;
    logic [ADDR_W-1:0] exp_a;
    logic [1:0] exp_st;
    logic [ADDR_W+DATA_W+4:0] got;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      if (i == clr_at + 1) clr_req = 1'b0;
      #1;
      exp_a  = ADDR_W'(i);
      exp_st = (i == DEPTH - 1) ? 2'b10 : 2'b01;
      if (bad_i < 0 && (mem_we !== 1'b1 || mem_addr !== exp_a || mem_wdata !== '0 ||
          {init_done, busy} !== exp_st ||
          (i != DEPTH - 1 && {req0_ready, req1_ready} !== 2'b00))) begin
        bad_i = i;
        got   = {mem_we, mem_addr, mem_wdata, init_done, busy, req0_ready, req1_ready};
      end
      if (i == clr_at) clr_req = 1'b1;
    end
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL %s: sweep step %0d got we/addr/wdata/done/busy/rdy=%h, required we=1 addr=%0d wdata=0",
               name, bad_i, got, bad_i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_req = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    step(); step();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem: got we=%b addr=%h wdata=%h, required all 0", mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({init_done, busy, req0_ready, req1_ready} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_status: got done/busy/r0/r1=%b, required 0100",
               {init_done, busy, req0_ready, req1_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    run_sweep("init_sweep", -1);
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_addr = 12'h010; req0_data = 32'hDEADBEEF; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL single0_ready: got r0/r1=%b, required 10", {req0_ready, req1_ready});
    end
    step(); req0_valid = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h010, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL single0_write: got we=%b addr=%h wdata=%h, required 1 010 deadbeef",
               mem_we, mem_addr, mem_wdata);
    end
    req1_valid = 1'b1; req1_addr = 12'h020; req1_data = 32'h12345678; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL single1_ready: got r0/r1=%b, required 01", {req0_ready, req1_ready});
    end
    step(); req1_valid = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h020, 32'h12345678}) begin
      failures++;
      $display("FAIL single1_write: got we=%b addr=%h wdata=%h, required 1 020 12345678",
               mem_we, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b0, 12'h020, 32'h12345678}) begin
      failures++;
      $display("FAIL idle_hold: got we=%b addr=%h wdata=%h, required 0 020 12345678",
               mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy [4];
    logic [ADDR_W+DATA_W:0] exp_mem [4];
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
    exp_mem[0] = {1'b1, 12'h100, 32'hA0A0A0A0};
    exp_mem[1] = {1'b1, 12'h200, 32'hB1B1B1B1};
    exp_mem[2] = exp_mem[0];
    exp_mem[3] = exp_mem[1];
    req0_addr = 12'h100; req0_data = 32'hA0A0A0A0;
    req1_addr = 12'h200; req1_data = 32'hB1B1B1B1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== exp_rdy[k]) begin
        failures++;
        $display("FAIL rr_grant%0d: got r0/r1=%b, required %b", k, {req0_ready, req1_ready}, exp_rdy[k]);
      end
      step();
      checks++;
      if ({mem_we, mem_addr, mem_wdata} !== exp_mem[k]) begin
        failures++;
        $display("FAIL rr_write%0d: got %h, required %h", k, {mem_we, mem_addr, mem_wdata}, exp_mem[k]);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] word_fff = 32'hFFFFFFFF;
    req0_addr = 12'hFFF; req0_data = 32'h1;
    req1_addr = 12'hFFF; req1_data = 32'h2;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      failures++;
      $display("FAIL b2b_first_grant: got r0/r1=%b, required 10", {req0_ready, req1_ready});
    end
    step(); req0_valid = 1'b0;
    if (mem_we && mem_addr == 12'hFFF) word_fff = mem_wdata;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 32'h1}) begin
      failures++;
      $display("FAIL b2b_write0: got we=%b addr=%h wdata=%h, required 1 fff 1", mem_we, mem_addr, mem_wdata);
    end
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL b2b_second_grant: got r0/r1=%b, required 01", {req0_ready, req1_ready});
    end
    step(); req1_valid = 1'b0;
    if (mem_we && mem_addr == 12'hFFF) word_fff = mem_wdata;
    step();
    checks++;
    if (word_fff !== 32'h2) begin
      failures++;
      $display("FAIL b2b_final_word: got word fff=%h, required 2", word_fff);
    end
  endtask

  task automatic test_clear();
    req1_addr = 12'h030; req1_data = 32'h55;
    clr_req = 1'b1; req1_valid = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready, init_done} !== 3'b001) begin
      failures++;
      $display("FAIL clr_no_grant: got r0/r1/done=%b, required 001", {req0_ready, req1_ready, init_done});
    end
    step(); clr_req = 1'b0;
    checks++;
    if ({mem_we, init_done, busy} !== 3'b001) begin
      failures++;
      $display("FAIL clr_enter_init: got we/done/busy=%b, required 001", {mem_we, init_done, busy});
    end
    run_sweep("clear_sweep", 100);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      failures++;
      $display("FAIL clr_first_run_grant: got r0/r1=%b, required 01", {req0_ready, req1_ready});
    end
    step(); req1_valid = 1'b0;
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h030, 32'h55}) begin
      failures++;
      $display("FAIL clr_served_write: got we=%b addr=%h wdata=%h, required 1 030 55",
               mem_we, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    clr_req = 1'b1;
    step(); clr_req = 1'b0;
    for (int n = 0; n < 2304 && !found; n++) begin
      step();
      if (mem_we === 1'b1 && mem_addr === 12'h800) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reach_800: got no write to addr 800 in 2304 cycles, required one");
    end
    req0_valid = 1'b1; req0_addr = 12'h040; req0_data = 32'h77;
    rst = 1'b1; #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL mid_rst_ready: got r0/r1=%b, required 00", {req0_ready, req1_ready});
    end
    step();
    checks++;
    if ({mem_we, mem_addr, init_done, busy} !== {1'b0, 12'h000, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL mid_rst_state: got we=%b addr=%h done=%b busy=%b, required 0 000 0 1",
               mem_we, mem_addr, init_done, busy);
    end
    rst = 1'b0;
    run_sweep("restart_sweep", -1);
    req0_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
